// File: rtl/multicycle_control_pkg.sv
// Shared constants, encodings and state enum for the multi-cycle MIPS controller.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALU_OP_W = 3;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;

    localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
    localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

    typedef logic [ALU_OP_W-1:0] alu_op_t;
    localparam alu_op_t ALU_ADD = 3'd0;
    localparam alu_op_t ALU_SUB = 3'd1;
    localparam alu_op_t ALU_AND = 3'd2;
    localparam alu_op_t ALU_OR  = 3'd3;
    localparam alu_op_t ALU_SLT = 3'd4;
    localparam alu_op_t ALU_SLL = 3'd5;
    localparam alu_op_t ALU_LUI = 3'd6;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WB = 4'd6,
        MEM_WR = 4'd7,
        ALU_WB = 4'd8,
        BRANCH = 4'd9,
        JUMP   = 4'd10,
        HALT   = 4'd11
    } state_t;

    typedef logic [1:0] pc_src_t;
    localparam pc_src_t PC_SRC_ALU    = 2'b00;
    localparam pc_src_t PC_SRC_ALUOUT = 2'b01;
    localparam pc_src_t PC_SRC_JUMP   = 2'b10;

    typedef logic [1:0] src_b_t;
    localparam src_b_t SRCB_REG    = 2'b00;
    localparam src_b_t SRCB_FOUR   = 2'b01;
    localparam src_b_t SRCB_IMM    = 2'b10;
    localparam src_b_t SRCB_BRANCH = 2'b11;

    typedef logic [1:0] m2r_t;
    localparam m2r_t M2R_ALUOUT = 2'b00;
    localparam m2r_t M2R_MDR    = 2'b01;
    localparam m2r_t M2R_PC     = 2'b10;

    typedef logic [1:0] fault_t;
    localparam fault_t FAULT_NONE    = 2'b00;
    localparam fault_t FAULT_ILLEGAL = 2'b01;
    localparam fault_t FAULT_TIMEOUT = 2'b10;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEM_RD) || (s == MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath signal bundle; the controller takes the slave side.
interface multicycle_control_if #(
    parameter int unsigned STATE_W = 4
);
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               alu_zero;
    logic               mem_ready;

    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               ir_write;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
    logic               reg_dst;
    logic               write_reg31;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [2:0]         alu_op;
    logic               ext_op;
    logic               instr_done;
    logic [1:0]         fault;
    logic [STATE_W-1:0] state;

    modport master (
        output opcode, funct, alu_zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
               mem_write, reg_write, reg_dst, write_reg31, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, ext_op, instr_done, fault, state
    );

    modport slave (
        input  opcode, funct, alu_zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, ir_write, iord, mem_read,
               mem_write, reg_write, reg_dst, write_reg31, mem_to_reg,
               alu_src_a, alu_src_b, alu_op, ext_op, instr_done, fault, state
    );
endinterface

// File: rtl/multicycle_control_alu_op_decode.sv
// R-type funct field to ALU operation, flagging unsupported funct codes.
module alu_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [FUNCT_W-1:0] funct_i,
    output alu_op_t            alu_op_o,
    output logic               illegal_o
);

    always_comb begin
        alu_op_o  = ALU_ADD;
        illegal_o = 1'b0;
        case (funct_i)
            FN_ADD:  alu_op_o = ALU_ADD;
            FN_SUB:  alu_op_o = ALU_SUB;
            FN_AND:  alu_op_o = ALU_AND;
            FN_OR:   alu_op_o = ALU_OR;
            FN_SLT:  alu_op_o = ALU_SLT;
            FN_SLL:  alu_op_o = ALU_SLL;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencing controller with memory-ready timeout and sticky fault.
// Optional cycle/instruction counters when PERF_COUNTERS_EN is defined.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned STATE_W      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.slave  bus
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0]          cycle_count,
    output logic [31:0]          instr_count
`endif
);

    localparam int unsigned WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;

    state_t            state_q, state_d;
    fault_t            fault_q, fault_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    alu_op_t funct_op;
    logic    funct_bad;
    logic    stall, timeout;

    logic pc_write_raw, pc_write_cond_raw, ir_write_raw, mem_read_raw;
    logic mem_write_raw, reg_write_raw, instr_done_raw;

    alu_op_decode u_alu_op_decode (
        .funct_i   (bus.funct),
        .alu_op_o  (funct_op),
        .illegal_o (funct_bad)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            fault_q <= FAULT_NONE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            wait_q  <= wait_d;
        end
    end

    // The timeout cycle is the MEM_WAIT_MAX-th consecutive not-ready cycle.
    assign stall   = is_wait_state(state_q) && !bus.mem_ready;
    assign timeout = stall && (MEM_WAIT_MAX != 0) && (wait_q == WAIT_W'(MEM_WAIT_MAX - 1));

    always_comb begin
        state_d           = state_q;
        fault_d           = fault_q;
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        ir_write_raw      = 1'b0;
        mem_read_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        reg_write_raw     = 1'b0;
        instr_done_raw    = 1'b0;
        bus.pc_source     = PC_SRC_ALU;
        bus.iord          = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.write_reg31   = 1'b0;
        bus.mem_to_reg    = M2R_ALUOUT;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_REG;
        bus.alu_op        = ALU_ADD;
        bus.ext_op        = 1'b1;

        case (state_q)
            FETCH: begin
                mem_read_raw  = 1'b1;
                bus.alu_src_b = SRCB_FOUR;
                if (bus.mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                bus.alu_src_b = SRCB_BRANCH;
                case (bus.opcode)
                    OP_RTYPE:                         state_d = EXEC_R;
                    OP_LW, OP_SW:                     state_d = ADDR;
                    OP_BEQ, OP_BNE:                   state_d = BRANCH;
                    OP_J, OP_JAL:                     state_d = JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = EXEC_I;
                    default: begin
                        state_d = HALT;
                        fault_d = FAULT_ILLEGAL;
                    end
                endcase
            end
            EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = funct_op;
                if (funct_bad) begin
                    state_d = HALT;
                    fault_d = FAULT_ILLEGAL;
                end else begin
                    state_d = ALU_WB;
                end
            end
            EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.ext_op    = 1'b0;
                case (bus.opcode)
                    OP_ADDI: begin
                        bus.alu_op = ALU_ADD;
                        bus.ext_op = 1'b1;
                    end
                    OP_ANDI: bus.alu_op = ALU_AND;
                    OP_ORI:  bus.alu_op = ALU_OR;
                    default: bus.alu_op = ALU_LUI;
                endcase
                state_d = ALU_WB;
            end
            ALU_WB: begin
                reg_write_raw  = 1'b1;
                bus.reg_dst    = (bus.opcode == OP_RTYPE);
                instr_done_raw = 1'b1;
                state_d        = FETCH;
            end
            ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                state_d       = (bus.opcode == OP_SW) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                bus.iord     = 1'b1;
                mem_read_raw = 1'b1;
                if (bus.mem_ready) state_d = MEM_WB;
            end
            MEM_WB: begin
                reg_write_raw  = 1'b1;
                bus.mem_to_reg = M2R_MDR;
                instr_done_raw = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                bus.iord      = 1'b1;
                mem_write_raw = 1'b1;
                if (bus.mem_ready) begin
                    instr_done_raw = 1'b1;
                    state_d        = FETCH;
                end
            end
            BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALU_SUB;
                bus.pc_source     = PC_SRC_ALUOUT;
                pc_write_cond_raw = (bus.opcode == OP_BEQ) ? bus.alu_zero : !bus.alu_zero;
                instr_done_raw    = 1'b1;
                state_d           = FETCH;
            end
            JUMP: begin
                pc_write_raw   = 1'b1;
                bus.pc_source  = PC_SRC_JUMP;
                instr_done_raw = 1'b1;
                if (bus.opcode == OP_JAL) begin
                    reg_write_raw   = 1'b1;
                    bus.write_reg31 = 1'b1;
                    bus.mem_to_reg  = M2R_PC;
                end
                state_d = FETCH;
            end
            HALT: state_d = HALT;
            default: state_d = FETCH;
        endcase

        if (timeout) begin
            state_d       = HALT;
            fault_d       = FAULT_TIMEOUT;
            mem_read_raw  = 1'b0;
            mem_write_raw = 1'b0;
        end

        wait_d = (stall && (state_d == state_q)) ? wait_q + WAIT_W'(1) : '0;
    end

    // Strobes are held low for the whole time reset is asserted.
    assign bus.pc_write      = pc_write_raw      & ~reset;
    assign bus.pc_write_cond = pc_write_cond_raw & ~reset;
    assign bus.ir_write      = ir_write_raw      & ~reset;
    assign bus.mem_read      = mem_read_raw      & ~reset;
    assign bus.mem_write     = mem_write_raw     & ~reset;
    assign bus.reg_write     = reg_write_raw     & ~reset;
    assign bus.instr_done    = instr_done_raw    & ~reset;
    assign bus.fault         = fault_q;
    assign bus.state         = STATE_W'(state_q);

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_q, instr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != HALT) cycle_q <= cycle_q + 32'd1;
            if (instr_done_raw)  instr_q <= instr_q + 32'd1;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control (MEM_WAIT_MAX = 15).
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3;
    localparam logic [3:0] S_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WB = 4'd6, S_MEM_WR = 4'd7;
    localparam logic [3:0] S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11;

    logic clk;
    logic reset;
    int   vectors;
    int   errors;

    multicycle_control_if #(.STATE_W(4)) bus ();

`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_count, instr_count;
    multicycle_control #(.MEM_WAIT_MAX(15), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );
`else
    multicycle_control #(.MEM_WAIT_MAX(15), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // {pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, instr_done}
    function automatic logic [6:0] strobes();
        return {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.mem_read,
                bus.mem_write, bus.reg_write, bus.instr_done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.alu_zero  = z;
        bus.mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        tick();
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        vectors++; if (strobes() !== 7'b0) begin errors++; $display("FAIL reset_strobes: got %b want %b", strobes(), 7'b0); end
        vectors++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus.state, S_FETCH); end
        vectors++; if (bus.fault !== 2'b00) begin errors++; $display("FAIL reset_fault: got %b want %b", bus.fault, 2'b00); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        do_reset();
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        vectors++; if ({bus.state, strobes()} !== {S_FETCH, 7'b1011000}) begin errors++; $display("FAIL add_fetch: got %0d/%b want %0d/%b", bus.state, strobes(), S_FETCH, 7'b1011000); end
        vectors++; if ({bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source} !== {1'b0, 1'b0, 2'b01, 3'd0, 2'b00}) begin errors++; $display("FAIL add_fetch_sel: got %b want %b", {bus.iord, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source}, 9'b000100000); end
        tick();
        vectors++; if ({bus.state, strobes(), bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== {S_DECODE, 7'b0, 1'b0, 2'b11, 3'd0}) begin errors++; $display("FAIL add_decode: got %0d/%b/%b/%b want 1/0000000/0/11", bus.state, strobes(), bus.alu_src_a, bus.alu_src_b); end
        tick();
        vectors++; if ({bus.state, strobes(), bus.alu_src_a, bus.alu_src_b, bus.alu_op} !== {S_EXEC_R, 7'b0, 1'b1, 2'b00, 3'd0}) begin errors++; $display("FAIL add_exec_r: got %0d/%b/%b/%b/%0d want 2/0000000/1/00/0", bus.state, strobes(), bus.alu_src_a, bus.alu_src_b, bus.alu_op); end
        tick();
        vectors++; if ({bus.state, strobes(), bus.reg_dst, bus.mem_to_reg} !== {S_ALU_WB, 7'b0000011, 1'b1, 2'b00}) begin errors++; $display("FAIL add_alu_wb: got %0d/%b/%b/%b want 8/0000011/1/00", bus.state, strobes(), bus.reg_dst, bus.mem_to_reg); end
        tick();
        vectors++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL add_return: got %0d want %0d", bus.state, S_FETCH); end
    endtask

    task automatic test_rfunct();
        logic [5:0] fn_tab [5] = '{6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        logic [2:0] op_tab [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        for (int i = 0; i < 5; i++) begin
            do_reset();
            drive(6'h00, fn_tab[i], 1'b0, 1'b1);
            tick();
            tick();
            vectors++; if ({bus.state, bus.alu_op} !== {S_EXEC_R, op_tab[i]}) begin errors++; $display("FAIL rfunct_%0h: got %0d/%0d want %0d/%0d", fn_tab[i], bus.state, bus.alu_op, S_EXEC_R, op_tab[i]); end
            tick();
            vectors++; if (bus.state !== S_ALU_WB) begin errors++; $display("FAIL rfunct_wb_%0h: got %0d want %0d", fn_tab[i], bus.state, S_ALU_WB); end
        end
    endtask

    task automatic test_itype();
        logic [5:0] opc_tab [4] = '{6'h08, 6'h0C, 6'h0D, 6'h0F};
        logic [2:0] alu_tab [4] = '{3'd0, 3'd2, 3'd3, 3'd6};
        logic       ext_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            drive(opc_tab[i], 6'h3F, 1'b0, 1'b1);
            tick();
            tick();
            vectors++; if ({bus.state, bus.alu_op, bus.ext_op, bus.alu_src_b} !== {S_EXEC_I, alu_tab[i], ext_tab[i], 2'b10}) begin errors++; $display("FAIL itype_%0h: got %0d/%0d/%b/%b want %0d/%0d/%b/10", opc_tab[i], bus.state, bus.alu_op, bus.ext_op, bus.alu_src_b, S_EXEC_I, alu_tab[i], ext_tab[i]); end
            tick();
            vectors++; if ({bus.state, strobes(), bus.reg_dst} !== {S_ALU_WB, 7'b0000011, 1'b0}) begin errors++; $display("FAIL itype_wb_%0h: got %0d/%b/%b want 8/0000011/0", opc_tab[i], bus.state, strobes(), bus.reg_dst); end
        end
    endtask

    task automatic test_lw_wait();
        logic [3:0] seq [8] = '{S_FETCH, S_DECODE, S_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_WB};
        do_reset();
        for (int c = 0; c < 8; c++) begin
            if (c > 0) tick();
            drive(6'h23, 6'h00, 1'b0, (c >= 3 && c <= 5) ? 1'b0 : 1'b1);
            vectors++; if (bus.state !== seq[c]) begin errors++; $display("FAIL lw_cycle%0d_state: got %0d want %0d", c, bus.state, seq[c]); end
            if (c == 2) begin
                vectors++; if ({bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op} !== {1'b1, 2'b10, 1'b1, 3'd0}) begin errors++; $display("FAIL lw_addr_sel: got %b%b%b%b want 1101000", bus.alu_src_a, bus.alu_src_b, bus.ext_op, bus.alu_op); end
            end
            if (c >= 3 && c <= 6) begin
                vectors++; if ({strobes(), bus.iord} !== {7'b0001000, 1'b1}) begin errors++; $display("FAIL lw_memrd%0d: got %b/%b want 0001000/1", c, strobes(), bus.iord); end
            end
            if (c == 7) begin
                vectors++; if ({strobes(), bus.mem_to_reg, bus.reg_dst} !== {7'b0000011, 2'b01, 1'b0}) begin errors++; $display("FAIL lw_memwb: got %b/%b/%b want 0000011/01/0", strobes(), bus.mem_to_reg, bus.reg_dst); end
            end
        end
        tick();
        vectors++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL lw_return: got %0d want %0d", bus.state, S_FETCH); end
    endtask

    task automatic test_sw();
        do_reset();
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        vectors++; if ({bus.state, strobes(), bus.iord} !== {S_MEM_WR, 7'b0000100, 1'b1}) begin errors++; $display("FAIL sw_wait: got %0d/%b/%b want 7/0000100/1", bus.state, strobes(), bus.iord); end
        tick();
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        vectors++; if ({bus.state, strobes()} !== {S_MEM_WR, 7'b0000101}) begin errors++; $display("FAIL sw_done: got %0d/%b want 7/0000101", bus.state, strobes()); end
        tick();
        vectors++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL sw_return: got %0d want %0d", bus.state, S_FETCH); end
    endtask

    task automatic test_branch();
        logic [5:0] opc_tab [4] = '{6'h04, 6'h05, 6'h04, 6'h05};
        logic       z_tab   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [6:0] exp_tab [4] = '{7'b0100001, 7'b0000001, 7'b0000001, 7'b0100001};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            drive(opc_tab[i], 6'h00, z_tab[i], 1'b1);
            tick();
            tick();
            vectors++; if ({bus.state, strobes(), bus.pc_source, bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== {S_BRANCH, exp_tab[i], 2'b01, 3'd1, 1'b1, 2'b00}) begin errors++; $display("FAIL branch_%0d: got %0d/%b/%b/%0d want %0d/%b/01/1", i, bus.state, strobes(), bus.pc_source, bus.alu_op, S_BRANCH, exp_tab[i]); end
            tick();
            vectors++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL branch_return_%0d: got %0d want %0d", i, bus.state, S_FETCH); end
        end
    endtask

    task automatic test_jump();
        do_reset();
        drive(6'h03, 6'h00, 1'b0, 1'b1);
        tick();
        tick();
        vectors++; if ({bus.state, strobes(), bus.write_reg31, bus.mem_to_reg, bus.pc_source} !== {S_JUMP, 7'b1000011, 1'b1, 2'b10, 2'b10}) begin errors++; $display("FAIL jal: got %0d/%b/%b/%b/%b want 10/1000011/1/10/10", bus.state, strobes(), bus.write_reg31, bus.mem_to_reg, bus.pc_source); end
        do_reset();
        drive(6'h02, 6'h00, 1'b0, 1'b1);
        tick();
        tick();
        vectors++; if ({bus.state, strobes(), bus.write_reg31, bus.pc_source} !== {S_JUMP, 7'b1000001, 1'b0, 2'b10}) begin errors++; $display("FAIL j: got %0d/%b/%b/%b want 10/1000001/0/10", bus.state, strobes(), bus.write_reg31, bus.pc_source); end
        tick();
        vectors++; if (bus.state !== S_FETCH) begin errors++; $display("FAIL j_return: got %0d want %0d", bus.state, S_FETCH); end
    endtask

    task automatic test_illegal();
        int bad;
        do_reset();
        drive(6'h3F, 6'h20, 1'b0, 1'b1);
        tick();
        tick();
        vectors++; if ({bus.state, bus.fault} !== {S_HALT, 2'b01}) begin errors++; $display("FAIL illegal_op: got %0d/%b want 11/01", bus.state, bus.fault); end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            drive(6'h00, 6'h20, c[0], 1'b1);
            if (strobes() !== 7'b0 || bus.state !== S_HALT || bus.fault !== 2'b01) bad++;
            tick();
        end
        vectors++; if (bad !== 0) begin errors++; $display("FAIL halt_quiet: got %0d bad cycles want 0", bad); end
        do_reset();
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        vectors++; if ({bus.state, bus.fault} !== {S_FETCH, 2'b00}) begin errors++; $display("FAIL halt_reset: got %0d/%b want 0/00", bus.state, bus.fault); end
        drive(6'h00, 6'h3F, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        vectors++; if ({bus.state, bus.fault} !== {S_HALT, 2'b01}) begin errors++; $display("FAIL illegal_funct: got %0d/%b want 11/01", bus.state, bus.fault); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            drive(6'h00, 6'h20, 1'b0, 1'b0);
            vectors++; if ({bus.state, strobes()} !== {S_FETCH, (k < 15) ? 7'b0001000 : 7'b0}) begin errors++; $display("FAIL timeout_wait%0d: got %0d/%b want 0/%b", k, bus.state, strobes(), (k < 15) ? 7'b0001000 : 7'b0); end
            tick();
        end
        vectors++; if ({bus.state, bus.fault} !== {S_HALT, 2'b10}) begin errors++; $display("FAIL timeout_halt: got %0d/%b want 11/10", bus.state, bus.fault); end
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        tick();
        vectors++; if ({bus.state, bus.fault, strobes()} !== {S_HALT, 2'b10, 7'b0}) begin errors++; $display("FAIL timeout_sticky: got %0d/%b/%b want 11/10/0000000", bus.state, bus.fault, strobes()); end
    endtask

    task automatic test_wait_boundary();
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            drive(6'h00, 6'h20, 1'b0, 1'b0);
            tick();
        end
        drive(6'h00, 6'h20, 1'b0, 1'b1);
        vectors++; if ({bus.state, strobes()} !== {S_FETCH, 7'b1011000}) begin errors++; $display("FAIL wait14_ready: got %0d/%b want 0/1011000", bus.state, strobes()); end
        tick();
        vectors++; if ({bus.state, bus.fault} !== {S_DECODE, 2'b00}) begin errors++; $display("FAIL wait14_decode: got %0d/%b want 1/00", bus.state, bus.fault); end
    endtask

    task automatic test_reset_mid_wr();
        do_reset();
        drive(6'h2B, 6'h00, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        vectors++; if ({bus.state, bus.mem_write} !== {S_MEM_WR, 1'b0}) begin errors++; $display("FAIL midwr_reset_high: got %0d/%b want 7/0", bus.state, bus.mem_write); end
        tick();
        reset = 1'b0;
        drive(6'h2B, 6'h00, 1'b0, 1'b0);
        vectors++; if ({bus.state, strobes(), bus.fault} !== {S_FETCH, 7'b0001000, 2'b00}) begin errors++; $display("FAIL midwr_fetch: got %0d/%b/%b want 0/0001000/00", bus.state, strobes(), bus.fault); end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        reset   = 1'b1;
        drive(6'h00, 6'h00, 1'b0, 1'b0);
        test_reset();
        test_add();
        test_rfunct();
        test_itype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_jump();
        test_illegal();
        test_timeout();
        test_wait_boundary();
        test_reset_mid_wr();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Sequencing controller for the multi-cycle variant of the MIPS datapath. One shared memory holds instructions and data, and one ALU also computes PC+4 and the branch target.
- Steps each instruction through fetch/decode/execute/memory/writeback, waits on a memory-ready handshake, and drives every datapath select and strobe.
- Replaces the single-cycle combinational control decoder. Sits between the instruction register, ALU, register file, memory and PC.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles the block waits for mem_ready before flagging a bus error; 0 disables the timeout.
- STATE_W, 4: width of the exported state encoding.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  6  instruction register bits [31:26].
- funct  in  6  instruction register bits [5:0].
- alu_zero  in  1  ALU zero flag, combinational, current cycle.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load because a branch is taken (already qualified by alu_zero).
- pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target {pc[31:28],addr26,00}.
- ir_write  out  1  load instruction register.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  1 selects rd, 0 selects rt.
- write_reg31  out  1  force destination register 31 (jal).
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link).
- alu_src_a  out  1  0 PC, 1 register A.
- alu_src_b  out  2  00 register B, 01 constant 4, 10 extended imm16, 11 sext(imm16)<<2.
- alu_op  out  3  ALU operation code (package constants).
- ext_op  out  1  1 sign-extend, 0 zero-extend imm16.
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction.
- fault  out  2  sticky: 00 none, 01 illegal opcode, 10 memory timeout.
- state  out  STATE_W  current state, for debug.

Behaviour:
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT.
- Reset: state=FETCH, fault=00, wait counter=0. While reset is high, every strobe (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, instr_done) is 0.
- All outputs are combinational functions of state. The only exceptions are the Mealy terms gated by mem_ready and alu_zero listed below.
- FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=ADD.
  - mem_ready=1: ir_write=1, pc_write=1, pc_source=00, next state DECODE.
  - mem_ready=0: stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut). Dispatch on opcode:
  - 0x00 -> EXEC_R.
  - 0x23, 0x2B -> ADDR.
  - 0x04, 0x05 -> BRANCH.
  - 0x02, 0x03 -> JUMP.
  - 0x08, 0x0C, 0x0D, 0x0F -> EXEC_I.
  - anything else -> HALT with fault=01.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT, 0x00 SLL. Any other funct -> HALT, fault=01. Otherwise next ALU_WB.
- EXEC_I: alu_src_b=10. 0x08 ADD with ext_op=1; 0x0C AND with ext_op=0; 0x0D OR with ext_op=0; 0x0F LUI with ext_op=0. Next ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=00, reg_dst=1 for R-type and 0 for I-type; instr_done=1. Next FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=ADD. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: iord=1, mem_read=1. Leaves for MEM_WB on mem_ready.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=01, instr_done=1. Next FETCH.
- MEM_WR: iord=1, mem_write=1. On mem_ready: instr_done=1, next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01. pc_write_cond = beq ? alu_zero : ~alu_zero. instr_done=1. Next FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. For jal also reg_write=1, write_reg31=1, mem_to_reg=10; the link value is the already-incremented PC. Next FETCH.
- Memory wait counter:
  - Counts consecutive cycles in FETCH, MEM_RD or MEM_WR with mem_ready=0; cleared on mem_ready or on any state change.
  - Reaching MEM_WAIT_MAX (when nonzero): next state HALT, fault=10, and no strobe is issued in that cycle.
- HALT: all strobes 0; absorbing state; only reset leaves it. fault holds its value until reset.
- mem_ready outside a waiting state is ignored.
- Reset asserted in any state, including mid-wait, overrides: the next state is FETCH.

Optional Feature:
- PERF_COUNTERS_EN defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0].
  - cycle_count increments every non-reset cycle outside HALT. instr_count increments on instr_done.
  - Both clear on reset and wrap modulo 2^32.
- Not defined: neither port nor the counter registers exist; all other behaviour is identical.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - ALU op codes: ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, LUI=6;
  - the state enum;
  - pc_source, alu_src_b and mem_to_reg encodings;
  - fault codes.
- Sub-module alu_op_decode: combinational funct-to-alu_op and illegal-funct flag, reused by EXEC_R.

Test Plan:
- add (opcode 0x00, funct 0x20), mem_ready held at 1 -> FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 and reg_dst=1 in ALU_WB; instr_done pulses in cycle 4.
- lw (opcode 0x23) with mem_ready low for 3 cycles in MEM_RD -> state stays MEM_RD for 3 cycles; MEM_WB asserts mem_to_reg=01; 5 states plus 3 wait cycles in total.
- beq (opcode 0x04) with alu_zero=1, then bne (opcode 0x05) with alu_zero=1 -> pc_write_cond=1 for beq, 0 for bne; both return to FETCH.
- jal (opcode 0x03) -> JUMP asserts pc_write, write_reg31, reg_write and mem_to_reg=10 in a single cycle.
- opcode 0x3F -> HALT with fault=01; no further strobes for 20 cycles; reset returns to FETCH with fault=00.
- mem_ready held at 0 in FETCH with MEM_WAIT_MAX=15 -> HALT with fault=10 after 15 cycles. Separately, reset asserted mid-MEM_WR -> FETCH on the next cycle with mem_write=0.
